// File: rtl/phase_counter.sv
// phase_counter: 1 s timebase and cyclic phase count for the traffic-light
// signal decoder. Provides run/hold and single-step control from two raw
// board buttons. Also provides the seconds left in the current light phase.
module phase_counter #(
  parameter int TICK_DIV        = 125000000,
  parameter int PERIOD          = 20,
  parameter int T1              = 8,
  parameter int T2              = 10,
  parameter int T3              = 18,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause_btn,
  input  logic       step_btn,
  output logic [7:0] count,
  output logic       tick,
  output logic       running,
  output logic [7:0] remain
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    CNT_LAST  = 8'(PERIOD - 1);
  localparam logic [7:0]    T1_B      = 8'(T1);
  localparam logic [7:0]    T2_B      = 8'(T2);
  localparam logic [7:0]    T3_B      = 8'(T3);
  // A PERIOD of 256 truncates to 0. The modulo-256 subtraction still gives
  // the correct remaining time for every count in the last phase.
  localparam logic [7:0]    PERIOD_B  = 8'(PERIOD);

  // Index 0 = pause button, index 1 = step button
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    acc;
  logic [1:0]    rise;
  logic [DW-1:0] db_cnt [2];

  logic [PW-1:0] presc;
  logic          pause_rise;
  logic          step_rise;
  logic          presc_term;
  logic          advance;
  logic [7:0]    count_nxt;

  function automatic logic [7:0] remain_of(input logic [7:0] c);
    if (c < T1_B)      return T1_B - c;
    else if (c < T2_B) return T2_B - c;
    else if (c < T3_B) return T3_B - c;
    else               return PERIOD_B - c;
  endfunction

  // Synchronize both buttons. The accepted level changes only after the
  // synchronized level has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      rise  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {step_btn, pause_btn};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        rise[i] <= 1'b0;
        if (sync2[i] != acc[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            acc[i]    <= sync2[i];
            db_cnt[i] <= '0;
            rise[i]   <= sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign pause_rise = rise[0];
  assign step_rise  = rise[1];
  assign presc_term = (presc == PRESC_MAX);
  // A step is honoured only while held. All events in one cycle are resolved
  // against the current value of running.
  assign advance    = (running & presc_term) | (step_rise & ~running);
  assign count_nxt  = (count == CNT_LAST) ? 8'd0 : count + 8'd1;

  // Prescaler, run/hold toggle, and count/remain update on each advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      count   <= 8'd0;
      tick    <= 1'b0;
      running <= 1'b1;
      remain  <= T1_B;
    end else begin
      tick <= advance;
      if (advance) begin
        count  <= count_nxt;
        remain <= remain_of(count_nxt);
      end
      // While held, the prescaler keeps its partial interval; a step clears it
      if (running) begin
        presc <= presc_term ? '0 : presc + 1'b1;
      end else if (step_rise) begin
        presc <= '0;
      end
      if (pause_rise) running <= ~running;
    end
  end

endmodule

// File: tb/tb_phase_counter.sv
// Testbench for phase_counter with a short timebase and short debounce.
// A behavioural model steps the count once every TICK_DIV running cycles.
// A clean button press lands 3+DEBOUNCE_CYCLES edges after it starts, provided
// it is held for at least DEBOUNCE_CYCLES cycles. Outputs are checked on every edge.
module tb_phase_counter;
  localparam int TICK_DIV = 4;
  localparam int PERIOD   = 20;
  localparam int T1       = 8;
  localparam int T2       = 10;
  localparam int T3       = 18;
  localparam int DC       = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pause_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic [7:0] count;
  logic       tick;
  logic       running;
  logic [7:0] remain;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc_n = 0;
  int m_count, m_presc, pause_due, step_due, pause_left, step_left;
  bit m_run, m_tick;

  phase_counter #(
    .TICK_DIV(TICK_DIV), .PERIOD(PERIOD), .T1(T1), .T2(T2), .T3(T3),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause_btn(pause_btn), .step_btn(step_btn),
    .count(count), .tick(tick), .running(running), .remain(remain)
  );

  always #5 clk = ~clk;

  function automatic int exp_remain(input int c);
    if (c < T1) return T1 - c;
    if (c < T2) return T2 - c;
    if (c < T3) return T3 - c;
    return PERIOD - c;
  endfunction

  task automatic model_reset();
    m_count = 0; m_presc = 0; m_run = 1'b1; m_tick = 1'b0;
    pause_due = -1; step_due = -1; pause_left = 0; step_left = 0;
    pause_btn = 1'b0; step_btn = 1'b0;
  endtask

  // One clock edge: advance the reference model, then release any button
  // whose hold time has elapsed.
  task automatic clk_edge();
    bit pe, se, adv;
    @(posedge clk);
    cyc_n++;
    pe  = (cyc_n == pause_due);
    se  = (cyc_n == step_due);
    adv = 1'b0;
    if (m_run) begin
      if (m_presc == TICK_DIV - 1) begin adv = 1'b1; m_presc = 0; end
      else m_presc++;
    end else if (se) begin
      adv = 1'b1; m_presc = 0;
    end
    if (adv) m_count = (m_count + 1) % PERIOD;
    if (pe) m_run = !m_run;
    m_tick = adv;
    #1;
    if (pause_left > 0) begin pause_left--; if (pause_left == 0) pause_btn = 1'b0; end
    if (step_left > 0)  begin step_left--;  if (step_left == 0)  step_btn = 1'b0;  end
  endtask

  task automatic press(input bit is_step, input int hold);
    int due;
    due = (hold >= DC) ? cyc_n + 3 + DC : -1;
    if (is_step) begin step_btn = 1'b1; step_left = hold; step_due = due; end
    else begin pause_btn = 1'b1; pause_left = hold; pause_due = due; end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL reset_running got %b want 1", running); end
    n_tests++; if (remain !== 8'(T1)) begin n_fail++; $display("FAIL reset_remain got %0d want %0d", remain, T1); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 90; i++) begin
      clk_edge();
      n_tests++;
      if ({count, tick, running, remain} !== {8'(m_count), m_tick, m_run, 8'(exp_remain(m_count))}) begin
        n_fail++;
        $display("FAIL free_run cyc=%0d count %0d/%0d tick %b/%b run %b/%b remain %0d/%0d", cyc_n,
                 count, m_count, tick, m_tick, running, m_run, remain, exp_remain(m_count));
      end
    end
  endtask

  task automatic test_pause();
    int a;
    a = 2 + $urandom_range(0, 5);
    for (int i = 0; i < 70; i++) begin
      clk_edge();
      n_tests++;
      if ({count, tick, running, remain} !== {8'(m_count), m_tick, m_run, 8'(exp_remain(m_count))}) begin
        n_fail++;
        $display("FAIL pause cyc=%0d count %0d/%0d tick %b/%b run %b/%b remain %0d/%0d", cyc_n,
                 count, m_count, tick, m_tick, running, m_run, remain, exp_remain(m_count));
      end
      if (i == a || i == a + 30) press(1'b0, 10);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 30; i++) begin
      clk_edge();
      n_tests++;
      if ({count, tick, running, remain} !== {8'(m_count), m_tick, m_run, 8'(exp_remain(m_count))}) begin
        n_fail++;
        $display("FAIL glitch cyc=%0d count %0d/%0d tick %b/%b run %b/%b remain %0d/%0d", cyc_n,
                 count, m_count, tick, m_tick, running, m_run, remain, exp_remain(m_count));
      end
      if (i == 2) press(1'b0, DC - 1);
      if (i == 14) press(1'b0, 1);
      if (i == 20) press(1'b1, DC - 1);
    end
  endtask

  task automatic test_step();
    int guard;
    press(1'b0, DC + 1);
    for (int r = 0; r < 48; r++) begin
      if (r == 2) begin
        // Hold reached (or exhausted the bound): issue repeated steps until count is 19
        if (m_run || m_count == PERIOD - 1) continue;
      end
      if (r > 2 && !m_run && m_count == PERIOD - 1) break;
      if (r > 0) press(1'b1, DC + 1);
      for (int i = 0; i < 12; i++) begin
        clk_edge();
        n_tests++;
        if ({count, tick, running, remain} !== {8'(m_count), m_tick, m_run, 8'(exp_remain(m_count))}) begin
          n_fail++;
          $display("FAIL step cyc=%0d count %0d/%0d tick %b/%b run %b/%b remain %0d/%0d", cyc_n,
                   count, m_count, tick, m_tick, running, m_run, remain, exp_remain(m_count));
        end
      end
    end
    n_tests++;
    if (m_run || m_count != PERIOD - 1) begin
      n_fail++; $display("FAIL step_reach_19 model count %0d run %b", m_count, m_run);
    end
    // Step from 19 wraps to 0 with remain back at the first phase length
    press(1'b1, DC + 1);
    guard = 0;
    while (!m_tick && guard < 20) begin clk_edge(); guard++; end
    n_tests++;
    if ({count, tick, remain} !== {8'd0, 1'b1, 8'(T1)}) begin
      n_fail++; $display("FAIL step_wrap count %0d want 0 tick %b want 1 remain %0d want %0d", count, tick, remain, T1);
    end
    for (int i = 0; i < 45; i++) begin
      clk_edge();
      n_tests++;
      if ({count, tick, running, remain} !== {8'(m_count), m_tick, m_run, 8'(exp_remain(m_count))}) begin
        n_fail++;
        $display("FAIL step_resume cyc=%0d count %0d/%0d tick %b/%b run %b/%b remain %0d/%0d", cyc_n,
                 count, m_count, tick, m_tick, running, m_run, remain, exp_remain(m_count));
      end
      if (i == 2) press(1'b0, DC + 1);
      if (i == 16) press(1'b1, DC + 2);
    end
  endtask

  task automatic test_coincidence();
    int guard;
    guard = 0;
    // With TICK_DIV=4 and a press landing 6 edges later, count 6 / prescaler 2
    // places the accepted pause edge on the terminal cycle that moves 7 -> 8.
    while (!(m_run && m_count == 6 && m_presc == 2) && guard < 200) begin
      clk_edge(); guard++;
    end
    n_tests++;
    if (guard >= 200) begin n_fail++; $display("FAIL coincidence_setup timeout count %0d", count); end
    press(1'b0, DC + 1);
    repeat (6) clk_edge();
    n_tests++;
    if ({count, tick, running} !== {8'd8, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL coincidence count %0d want 8 tick %b want 1 running %b want 0", count, tick, running);
    end
    for (int i = 0; i < 40; i++) begin
      clk_edge();
      n_tests++;
      if ({count, tick, running, remain} !== {8'(m_count), m_tick, m_run, 8'(exp_remain(m_count))}) begin
        n_fail++;
        $display("FAIL coincidence_hold cyc=%0d count %0d/%0d tick %b/%b run %b/%b remain %0d/%0d", cyc_n,
                 count, m_count, tick, m_tick, running, m_run, remain, exp_remain(m_count));
      end
      if (i == 25) press(1'b0, DC);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (!(m_run && m_count == 13) && guard < 200) begin clk_edge(); guard++; end
    n_tests++;
    if (guard >= 200) begin n_fail++; $display("FAIL async_setup timeout count %0d", count); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({count, remain, running, tick} !== {8'd0, 8'(T1), 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL async_reset count %0d remain %0d running %b tick %b want 0 %0d 1 0", count, remain, running, tick, T1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      n_tests++;
      if ({count, tick, running, remain} !== {8'(m_count), m_tick, m_run, 8'(exp_remain(m_count))}) begin
        n_fail++;
        $display("FAIL after_reset cyc=%0d count %0d/%0d tick %b/%b run %b/%b remain %0d/%0d", cyc_n,
                 count, m_count, tick, m_tick, running, m_run, remain, exp_remain(m_count));
      end
    end
  endtask

  task automatic test_back_to_back();
    int gap, hold, kind;
    gap = 0;
    for (int i = 0; i < 600; i++) begin
      clk_edge();
      n_tests++;
      if ({count, tick, running, remain} !== {8'(m_count), m_tick, m_run, 8'(exp_remain(m_count))}) begin
        n_fail++;
        $display("FAIL random cyc=%0d count %0d/%0d tick %b/%b run %b/%b remain %0d/%0d", cyc_n,
                 count, m_count, tick, m_tick, running, m_run, remain, exp_remain(m_count));
      end
      if (gap > 0) gap--;
      else begin
        hold = $urandom_range(1, 6);
        kind = $urandom_range(0, 3);
        if (kind == 0 || kind == 3) press(1'b0, hold);
        if (kind == 1 || kind == 3) press(1'b1, hold);
        gap = hold + DC + 4 + $urandom_range(0, 6);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_pause();
    test_glitch();
    test_step();
    test_coincidence();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
